// File: rtl/wb_ctrl_if.sv
// wb_ctrl_if: MEM-stage bundle handshake and register-file write-back bus
// for wb_ctrl. The slave modport is the sequencer; the master modport is the
// MEM stage / regfile side that drives bundles and observes the write port.
interface wb_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_wb_sel;
  logic        in_reg_wr;
  logic [2:0]  in_wr_reg;
  logic        in_is_load;
  logic        in_halt;
  logic        mem_done;
  logic        flush;
  logic [1:0]  wb_sel;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_reg;
  logic        halt;
  logic        mem_err;
  logic        busy;
  logic [15:0] retire_cnt;

  modport slave (
    input  in_valid, in_wb_sel, in_reg_wr, in_wr_reg, in_is_load, in_halt,
    input  mem_done, flush,
    output in_ready, wb_sel, rf_wr_en, rf_wr_reg, halt, mem_err, busy,
    output retire_cnt
  );

  modport master (
    output in_valid, in_wb_sel, in_reg_wr, in_wr_reg, in_is_load, in_halt,
    output mem_done, flush,
    input  in_ready, wb_sel, rf_wr_en, rf_wr_reg, halt, mem_err, busy,
    input  retire_cnt
  );
endinterface

// File: rtl/wb_ctrl.sv
// wb_ctrl: write-back sequencer between MEM and the register-file write port.
// Accepts one bundle per cycle, stalls loads until mem_done (with timeout),
// commits each bundle in exactly one cycle and latches a sticky halt.
// Optional macro WB_RETIRE_CNT_EN builds the 16-bit retired-instruction
// counter; without it retire_cnt is tied to zero.
module wb_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 8
) (
  input logic      clk,
  input logic      rst,
  wb_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_MEM,
    S_COMMIT,
    S_HALTED
  } state_t;

  state_t           state_q;
  logic             reg_wr_q;
  logic             halt_lat_q;
  logic             supp_q;
  logic [1:0]       lat_sel_q;
  logic [2:0]       lat_reg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       wb_sel_q;
  logic [2:0]       rf_wr_reg_q;
  logic             halt_q;
  logic             mem_err_q;

  logic             ready_d;
  logic             accept_d;
  logic             timeout_d;

  // Handshake: ready in IDLE or in a non-halting COMMIT; flush blocks accept.
  always_comb begin
    ready_d   = (state_q == S_IDLE) || ((state_q == S_COMMIT) && !halt_lat_q);
    accept_d  = bus.in_valid && ready_d && !bus.flush;
    timeout_d = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
  end

  // Sequencer FSM with latched bundle fields and registered write-back outputs.
  // wb_sel/rf_wr_reg outputs are loaded only on the edge entering COMMIT, so
  // they show the committing bundle and hold their value everywhere else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      reg_wr_q    <= 1'b0;
      halt_lat_q  <= 1'b0;
      supp_q      <= 1'b0;
      lat_sel_q   <= '0;
      lat_reg_q   <= '0;
      cnt_q       <= '0;
      wb_sel_q    <= '0;
      rf_wr_reg_q <= '0;
      halt_q      <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_COMMIT: begin
          if (bus.flush) begin
            state_q    <= S_IDLE;
            reg_wr_q   <= 1'b0;
            halt_lat_q <= 1'b0;
            supp_q     <= 1'b0;
          end else if ((state_q == S_COMMIT) && halt_lat_q) begin
            state_q <= S_HALTED;
            halt_q  <= 1'b1;
          end else if (accept_d) begin
            reg_wr_q   <= bus.in_reg_wr;
            halt_lat_q <= bus.in_halt;
            supp_q     <= 1'b0;
            lat_sel_q  <= bus.in_wb_sel;
            lat_reg_q  <= bus.in_wr_reg;
            if (bus.in_is_load) begin
              state_q <= S_WAIT_MEM;
            end else begin
              state_q     <= S_COMMIT;
              wb_sel_q    <= bus.in_wb_sel;
              rf_wr_reg_q <= bus.in_wr_reg;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT_MEM: begin
          if (bus.flush) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            reg_wr_q   <= 1'b0;
            halt_lat_q <= 1'b0;
            supp_q     <= 1'b0;
          end else if (bus.mem_done || timeout_d) begin
            // mem_done has priority over a coincident timeout.
            state_q     <= S_COMMIT;
            cnt_q       <= '0;
            wb_sel_q    <= lat_sel_q;
            rf_wr_reg_q <= lat_reg_q;
            if (!bus.mem_done) begin
              supp_q    <= 1'b1;
              mem_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_HALTED: begin
          state_q <= S_HALTED;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [15:0] retire_q;

  // Count every unflushed COMMIT cycle, including suppressed and halt bundles.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q <= '0;
    end else if ((state_q == S_COMMIT) && !bus.flush) begin
      retire_q <= retire_q + 16'd1;
    end
  end

  assign bus.retire_cnt = retire_q;
`else
  assign bus.retire_cnt = '0;
`endif

  assign bus.in_ready  = ready_d;
  assign bus.rf_wr_en  = (state_q == S_COMMIT) && reg_wr_q && !supp_q && !bus.flush;
  assign bus.wb_sel    = wb_sel_q;
  assign bus.rf_wr_reg = rf_wr_reg_q;
  assign bus.halt      = halt_q;
  assign bus.mem_err   = mem_err_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
- Write-back sequencer between the MEM stage and the register-file write port.
- Accepts one instruction bundle per cycle with a valid/ready handshake.
- Stalls loads until memory data is ready, and times out hung loads.
- Drives the write-back select, regfile write enable and write register, then latches the processor halt.

Parameters:
- MEM_TIMEOUT, 64, max cycles spent in WAIT_MEM before the load is abandoned (legal range 2..255).
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  MEM stage presents a bundle.
- in_ready  output  1  block can accept a bundle this cycle.
- in_wb_sel  input  2  write-back source: 00 mem data, 01 exe result, 10 extend, 11 PC_Next.
- in_reg_wr  input  1  instruction writes the register file.
- in_wr_reg  input  3  destination register R0..R7.
- in_is_load  input  1  instruction needs memory data.
- in_halt  input  1  instruction is HALT.
- mem_done  input  1  memory read data valid this cycle.
- flush  input  1  discard any un-committed bundle.
- wb_sel  output  2  select to the write-back mux.
- rf_wr_en  output  1  regfile write strobe.
- rf_wr_reg  output  3  regfile write address.
- halt  output  1  processor halted (sticky).
- mem_err  output  1  load timeout occurred (sticky).
- busy  output  1  state is not IDLE.
- retire_cnt  output  16  retired instruction count (see Optional Feature).

Behaviour:
- States: IDLE, WAIT_MEM, COMMIT, HALTED. Encoding is free.
- Reset (rst=1 at a clk edge):
  - state=IDLE; wb_sel=00, rf_wr_reg=000.
  - Internal latched fields cleared; wait counter=0.
  - halt=0, mem_err=0, retire_cnt=0.
  - Reset mid-operation abandons any latched bundle with no write.
- in_ready = 1 in IDLE, or in COMMIT when the latched halt=0; 0 otherwise. Accept = in_valid & in_ready & ~flush.
- On accept, latch wb_sel, reg_wr, wr_reg, is_load and halt. Next state is WAIT_MEM if in_is_load, else COMMIT.
- WAIT_MEM:
  - Counter increments each cycle.
  - mem_done=1 → COMMIT.
  - Else, counter == MEM_TIMEOUT-1 → set mem_err, mark the bundle "suppressed", go COMMIT.
  - mem_done and timeout in the same cycle: mem_done wins, no error.
  - Counter clears on leaving WAIT_MEM.
- COMMIT (exactly one cycle per bundle):
  - rf_wr_en = latched reg_wr & ~suppressed & ~flush; combinational from state and latched fields.
  - wb_sel and rf_wr_reg show the latched values.
  - If latched halt → HALTED, no accept.
  - Else if accept occurs → WAIT_MEM or COMMIT per the new bundle (back-to-back).
  - Else → IDLE.
- Throughput: non-load bundles sustain 1 per cycle. Bundle accepted at cycle t commits at t+1. A load commits in the cycle after mem_done is sampled.
- rf_wr_en is 0 in every state except COMMIT. wb_sel and rf_wr_reg hold their last values outside COMMIT.
- HALTED: halt=1, in_ready=0, rf_wr_en=0. Ignores in_valid and flush; only rst leaves it.
- flush=1 in IDLE, WAIT_MEM or COMMIT:
  - Next state IDLE, latched bundle discarded, no accept that cycle.
  - In COMMIT the write is cancelled and a latched halt is not taken.
- busy = (state != IDLE).

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined: retire_cnt increments by 1 on each COMMIT cycle with flush=0, including suppressed and halt bundles. It wraps from 0xFFFF to 0x0000.
- Undefined: the counter logic is not built and retire_cnt is tied to 16'h0000.

Test Plan:
- Reset, then 3 back-to-back non-loads (sel=01, reg R1,R2,R3, reg_wr=1) → rf_wr_en high on 3 consecutive cycles at t+1..t+3 with rf_wr_reg 1,2,3; in_ready stays 1.
- Load to R5, mem_done asserted 4 cycles after accept → in_ready=0 during wait; a single rf_wr_en pulse with wb_sel=00, rf_wr_reg=5 in the cycle after mem_done; mem_err=0.
- Load with mem_done never asserted, MEM_TIMEOUT=64 → after 64 WAIT_MEM cycles, mem_err=1 and the COMMIT cycle has rf_wr_en=0. A following non-load then commits normally.
- mem_done coincident with the timeout cycle → write occurs, mem_err stays 0.
- Flush in COMMIT of a reg_wr bundle, and flush in WAIT_MEM → no rf_wr_en, state IDLE next cycle. With WB_RETIRE_CNT_EN, retire_cnt is unchanged.
- HALT bundle (sel=11, reg_wr=1, R7) → R7 is written in COMMIT, then halt=1 and in_ready=0. Later flush and in_valid have no effect; rst clears halt.
